// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and owner encoding for the memory port arbiter.
`default_nettype none

package arb_pkg;

  localparam int STATE_W = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 6'b000001,
    ST_IRD  = 6'b000010,
    ST_IRW  = 6'b000100,
    ST_DRD  = 6'b001000,
    ST_DRW  = 6'b010000,
    ST_DWR  = 6'b100000
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // IDLE reports OWN_I; callers that care about ownership in IDLE qualify it with the grant.
  function automatic logic owner_of(input arb_state_t s);
    return (s == ST_DRD || s == ST_DRW || s == ST_DWR) ? OWN_D : OWN_I;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_req_latch.sv
// arb_req_latch: captures the granted request and drives the memory-side address/data/strobe lines.
`default_nettype none

module arb_req_latch
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                owner,
  input  logic [ADDR_W-1:0]   instr_addr,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic                drive_req,
  input  logic                drive_wr,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb
);

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  // Instruction fetches carry no write payload, so their data/strobe are captured as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (load) begin
      addr_q  <= (owner == OWN_D) ? data_addr : instr_addr;
      wdata_q <= (owner == OWN_D) ? data_wdata : '0;
      wstrb_q <= (owner == OWN_D) ? data_wstrb : '0;
    end
  end

  always_comb begin
    m_addr  = drive_req ? addr_q  : '0;
    m_wdata = drive_wr  ? wdata_q : '0;
    m_wstrb = drive_wr  ? wstrb_q : '0;
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between CPU instruction and data channels, data first.
// Optional feature macro: ARB_PERF_CNT_EN adds per-requester wait-cycle counters.
`default_nettype none

module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rvalid,
  input  logic                i_rready,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_wen,
  input  logic                d_ren,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_req_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rvalid,
  input  logic                d_rready,
  output logic [ADDR_W-1:0]   m_addr,
  output logic                m_wen,
  output logic                m_ren,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_req_ready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rvalid,
  output logic                m_rready
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         arb_i_wait_cnt,
  output logic [31:0]         arb_d_wait_cnt
`endif
);

  arb_state_t state, next_state;
  logic       load;
  logic       grant_owner;
  logic       drive_req;
  logic       drive_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    load        = 1'b0;
    grant_owner = OWN_I;
    drive_req   = 1'b0;
    drive_wr    = 1'b0;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    i_rdata     = '0;
    i_rvalid    = 1'b0;
    d_rdata     = '0;
    d_rvalid    = 1'b0;
    m_wen       = 1'b0;
    m_ren       = 1'b0;
    m_rready    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (d_wen || d_ren) begin
          next_state  = d_wen ? ST_DWR : ST_DRD;
          grant_owner = OWN_D;
          load        = 1'b1;
          d_req_ready = 1'b1;
        end else if (i_req_valid) begin
          next_state  = ST_IRD;
          load        = 1'b1;
          i_req_ready = 1'b1;
        end
      end
      ST_DWR: begin
        m_wen     = 1'b1;
        drive_req = 1'b1;
        drive_wr  = 1'b1;
        if (m_req_ready) next_state = ST_IDLE;
      end
      ST_DRD: begin
        m_ren     = 1'b1;
        drive_req = 1'b1;
        if (m_req_ready) next_state = ST_DRW;
      end
      ST_IRD: begin
        m_ren     = 1'b1;
        drive_req = 1'b1;
        if (m_req_ready) next_state = ST_IRW;
      end
      // Response phase is a pure pass-through so read data costs no extra cycle.
      ST_DRW: begin
        m_rready = d_rready;
        d_rvalid = m_rvalid;
        d_rdata  = m_rdata;
        if (m_rvalid && d_rready) next_state = ST_IDLE;
      end
      ST_IRW: begin
        m_rready = i_rready;
        i_rvalid = m_rvalid;
        i_rdata  = m_rdata;
        if (m_rvalid && i_rready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  arb_req_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_latch (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .owner      (grant_owner),
    .instr_addr (i_req_addr),
    .data_addr  (d_addr),
    .data_wdata (d_wdata),
    .data_wstrb (d_wstrb),
    .drive_req  (drive_req),
    .drive_wr   (drive_wr),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb)
  );

`ifdef ARB_PERF_CNT_EN
  logic i_is_owner;
  logic d_is_owner;

  // The grant cycle in IDLE counts as ownership for the winner.
  assign i_is_owner = i_req_ready || (state != ST_IDLE && owner_of(state) == OWN_I);
  assign d_is_owner = d_req_ready || (state != ST_IDLE && owner_of(state) == OWN_D);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arb_i_wait_cnt <= '0;
      arb_d_wait_cnt <= '0;
    end else begin
      if (i_req_valid && !i_is_owner)          arb_i_wait_cnt <= arb_i_wait_cnt + 32'd1;
      if ((d_wen || d_ren) && !d_is_owner)     arb_d_wait_cnt <= arb_d_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (perf counters checked when ARB_PERF_CNT_EN is set).
`default_nettype none

module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic [ADDR_W-1:0]   i_req_addr;
  logic                i_req_valid;
  logic                i_req_ready;
  logic [DATA_W-1:0]   i_rdata;
  logic                i_rvalid;
  logic                i_rready;
  logic [ADDR_W-1:0]   d_addr;
  logic                d_wen;
  logic                d_ren;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_wstrb;
  logic                d_req_ready;
  logic [DATA_W-1:0]   d_rdata;
  logic                d_rvalid;
  logic                d_rready;
  logic [ADDR_W-1:0]   m_addr;
  logic                m_wen;
  logic                m_ren;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_req_ready;
  logic [DATA_W-1:0]   m_rdata;
  logic                m_rvalid;
  logic                m_rready;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]         arb_i_wait_cnt;
  logic [31:0]         arb_d_wait_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_addr  (i_req_addr),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_rdata     (i_rdata),
    .i_rvalid    (i_rvalid),
    .i_rready    (i_rready),
    .d_addr      (d_addr),
    .d_wen       (d_wen),
    .d_ren       (d_ren),
    .d_wdata     (d_wdata),
    .d_wstrb     (d_wstrb),
    .d_req_ready (d_req_ready),
    .d_rdata     (d_rdata),
    .d_rvalid    (d_rvalid),
    .d_rready    (d_rready),
    .m_addr      (m_addr),
    .m_wen       (m_wen),
    .m_ren       (m_ren),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_req_ready (m_req_ready),
    .m_rdata     (m_rdata),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready)
`ifdef ARB_PERF_CNT_EN
    ,
    .arb_i_wait_cnt (arb_i_wait_cnt),
    .arb_d_wait_cnt (arb_d_wait_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {i_req_ready, d_req_ready, i_rvalid, d_rvalid, m_wen, m_ren, m_rready}
  function automatic logic [6:0] ctl();
    return {i_req_ready, d_req_ready, i_rvalid, d_rvalid, m_wen, m_ren, m_rready};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    i_req_addr = '0; i_req_valid = 1'b0; i_rready = 1'b0;
    d_addr = '0; d_wen = 1'b0; d_ren = 1'b0; d_wdata = '0; d_wstrb = '0; d_rready = 1'b0;
    m_req_ready = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
    settle();
    chk("reset_ctl", 64'(ctl()), 64'd0);
    chk("reset_maddr", 64'(m_addr), 64'd0);
    chk("reset_mwdata", 64'({m_wdata, m_wstrb}), 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Instruction fetch alone; memory accepts on the second request cycle.
    i_req_addr = 32'h100; i_req_valid = 1'b1; i_rready = 1'b1;
    settle();
    chk("i_grant_ctl", 64'(ctl()), 64'b1000000);
    tick();
    i_req_valid = 1'b0;
    chk("i_req_ctl", 64'(ctl()), 64'b0000010);
    chk("i_req_addr", 64'(m_addr), 64'h100);
    tick();
    chk("i_req_hold_addr", 64'(m_addr), 64'h100);
    chk("i_req_hold_ctl", 64'(ctl()), 64'b0000010);
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h00000013;
    settle();
    chk("i_resp_ctl", 64'(ctl()), 64'b0010001);
    chk("i_resp_data", 64'(i_rdata), 64'h13);
    tick();
    m_rvalid = 1'b0; m_rdata = '0;
    settle();
    chk("i_done_ctl", 64'(ctl()), 64'd0);

    // Data write; inputs scrambled after the grant to prove the latch holds.
    d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011; d_wen = 1'b1;
    settle();
    chk("dw_grant_ctl", 64'(ctl()), 64'b0100000);
    tick();
    d_wen = 1'b0; d_addr = 32'hFFF; d_wdata = '0; d_wstrb = 4'hF;
    settle();
    chk("dw_ctl", 64'(ctl()), 64'b0000100);
    chk("dw_addr", 64'(m_addr), 64'h200);
    chk("dw_data", 64'({m_wdata, m_wstrb}), {28'd0, 32'hDEADBEEF, 4'b0011});
    tick();
    chk("dw_hold_ctl", 64'(ctl()), 64'b0000100);
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0;
    settle();
    chk("dw_done_ctl", 64'(ctl()), 64'd0);
    chk("dw_done_strb", 64'(m_wstrb), 64'd0);

    // Collision: D read wins, pending I fetch follows.
    i_req_addr = 32'h104; i_req_valid = 1'b1;
    d_addr = 32'h300; d_ren = 1'b1; d_rready = 1'b1;
    settle();
    chk("col_grant_ctl", 64'(ctl()), 64'b0100000);
    tick();
    d_ren = 1'b0;
    chk("col_d_addr", 64'(m_addr), 64'h300);
    chk("col_d_ctl", 64'(ctl()), 64'b0000010);
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hAAAA5555;
    settle();
    chk("col_d_resp_ctl", 64'(ctl()), 64'b0001001);
    chk("col_d_rdata", 64'(d_rdata), 64'hAAAA5555);
    tick();
    m_rvalid = 1'b0;
    settle();
    chk("col_i_grant_ctl", 64'(ctl()), 64'b1000000);
    tick();
    i_req_valid = 1'b0;
    chk("col_i_addr", 64'(m_addr), 64'h104);
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h55;
    settle();
    chk("col_i_resp_ctl", 64'(ctl()), 64'b0010001);
    chk("col_i_rdata", 64'(i_rdata), 64'h55);
    tick();
    m_rvalid = 1'b0;

    // Backpressure on both the request and the response side.
    d_addr = 32'h400; d_ren = 1'b1; d_rready = 1'b1;
    tick();
    d_ren = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("bp_req_stable", 64'({m_addr, m_wen, m_ren}), {30'd0, 32'h400, 2'b01});
      tick();
    end
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1234; d_rready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("bp_resp_stall_ctl", 64'(ctl()), 64'b0001000);
      tick();
    end
    d_rready = 1'b1;
    settle();
    chk("bp_resp_ctl", 64'(ctl()), 64'b0001001);
    chk("bp_rdata", 64'(d_rdata), 64'h1234);
    tick();
    m_rvalid = 1'b0;
    settle();
    chk("bp_exit_ctl", 64'(ctl()), 64'd0);

    // Asynchronous reset while waiting for read data.
    d_addr = 32'h500; d_ren = 1'b1;
    tick();
    d_ren = 1'b0; m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h9999;
    settle();
    chk("rst_pre_ctl", 64'(ctl()), 64'b0001001);
    rst = 1'b0;
    settle();
    chk("rst_mid_ctl", 64'(ctl()), 64'd0);
    chk("rst_mid_data", 64'({m_addr, d_rdata}), 64'd0);
    m_rvalid = 1'b0; m_rdata = '0;
    tick();
    rst = 1'b1;
    tick();
    i_req_addr = 32'h600; i_req_valid = 1'b1;
    settle();
    chk("rst_post_grant", 64'(ctl()), 64'b1000000);
    tick();
    i_req_valid = 1'b0;
    chk("rst_post_addr", 64'(m_addr), 64'h600);
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h77;
    settle();
    chk("rst_post_rdata", 64'({i_rvalid, i_rdata}), {31'd0, 1'b1, 32'h77});
    tick();
    m_rvalid = 1'b0;

`ifdef ARB_PERF_CNT_EN
    // I waits through the collision cycle plus four DWR cycles: 5 counted cycles.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("perf_reset", 64'({arb_i_wait_cnt, arb_d_wait_cnt}), 64'd0);
    i_req_addr = 32'h700; i_req_valid = 1'b1;
    d_addr = 32'h800; d_wdata = 32'h1; d_wstrb = 4'hF; d_wen = 1'b1;
    tick();
    d_wen = 1'b0;
    tick(); tick(); tick();
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0;
    settle();
    chk("perf_i_grant", 64'(ctl()), 64'b1000000);
    chk("perf_i_cnt", 64'(arb_i_wait_cnt), 64'd5);
    chk("perf_d_cnt", 64'(arb_d_wait_cnt), 64'd0);
    tick();
    i_req_valid = 1'b0;
    m_req_ready = 1'b1;
    tick();
    m_req_ready = 1'b0; m_rvalid = 1'b1;
    tick();
    m_rvalid = 1'b0;
    chk("perf_i_cnt_final", 64'(arb_i_wait_cnt), 64'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (rst && m_wen && m_ren) begin
      n_checks++;
      n_fail++;
      $error("FAIL wen_ren_exclusive observed=both expected=at_most_one");
    end
  end

endmodule

`default_nettype wire
